// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter.
//   arb_state_t : FSM states (idle, command issued to controller, ack to requester)
//   arb_port_t  : requester identity, P_NONE when nobody is requesting
//   NPORTS      : number of requesters sharing the controller port
package sdram_arb_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_ACK} arb_state_t;
  typedef enum logic [1:0] {P_NONE, P_VID, P_DL, P_CPU} arb_port_t;

  localparam int unsigned NPORTS = 3;

endpackage

// File: rtl/sdram_arb_prio.sv
// Combinational winner selection for the SDRAM port arbiter.
// Ports:
//   vid_req, dl_req, cpu_req : level requests
//   cpu_aged                 : CPU has waited long enough to outrank DL
//   winner                   : selected port, P_NONE when no request
// VID is always highest; an aged CPU jumps ahead of DL.
module sdram_arb_prio
  import sdram_arb_pkg::*;
(
  input  logic      vid_req,
  input  logic      dl_req,
  input  logic      cpu_req,
  input  logic      cpu_aged,
  output arb_port_t winner
);

  always_comb begin
    winner = P_NONE;
    if (vid_req) begin
      winner = P_VID;
    end else if (cpu_req && cpu_aged) begin
      winner = P_CPU;
    end else if (dl_req) begin
      winner = P_DL;
    end else if (cpu_req) begin
      winner = P_CPU;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between video fetch (VID), data_io loader (DL) and CPU.
// One transaction at a time: the winner's command is latched in IDLE, held on mem_* while
// mem_req is high, and the winner gets a one-cycle ack (with rd_data for reads) after mem_ack.
// Ports:
//   clk_sys, rst_n                     : clock, asynchronous active-low reset
//   {vid,dl,cpu}_req/we/addr/din/be    : requester commands (vid_we unused, VID is read-only)
//   {vid,dl,cpu}_ack                   : one-cycle completion pulses
//   rd_data                            : read data, valid with the matching ack
//   mem_req/we/addr/din/be             : latched command to the SDRAM controller
//   mem_ack, mem_dout                  : controller completion pulse and read data
//   busy                               : high whenever the FSM is not idle
// Optional feature: define SDRAM_ARB_AGE_EN to let a CPU that waited AGE_LIMIT cycles
// outrank DL. Without it priority is fixed VID > DL > CPU.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned AGE_LIMIT = 15
) (
  input  logic                clk_sys,
  input  logic                rst_n,
  input  logic                vid_req,
  input  logic                vid_we,
  input  logic [ADDR_W-1:0]   vid_addr,
  input  logic [DATA_W-1:0]   vid_din,
  input  logic [DATA_W/8-1:0] vid_be,
  output logic                vid_ack,
  input  logic                dl_req,
  input  logic                dl_we,
  input  logic [ADDR_W-1:0]   dl_addr,
  input  logic [DATA_W-1:0]   dl_din,
  input  logic [DATA_W/8-1:0] dl_be,
  output logic                dl_ack,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_din,
  input  logic [DATA_W/8-1:0] cpu_be,
  output logic                cpu_ack,
  output logic [DATA_W-1:0]   rd_data,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_din,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_dout,
  output logic                busy
);

  localparam int unsigned BE_W = DATA_W / 8;

  arb_state_t        state_q;
  arb_port_t         grant_q;
  arb_port_t         winner;
  logic              cpu_aged;
  logic [NPORTS-1:0] req_vec;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;
  logic [BE_W-1:0]   sel_be;

  logic unused_vid_we;
  assign unused_vid_we = vid_we;

  assign req_vec = {vid_req, dl_req, cpu_req};

  sdram_arb_prio u_prio (
    .vid_req  (vid_req),
    .dl_req   (dl_req),
    .cpu_req  (cpu_req),
    .cpu_aged (cpu_aged),
    .winner   (winner)
  );

`ifdef SDRAM_ARB_AGE_EN
  localparam int unsigned AGE_W = $clog2(AGE_LIMIT + 1);
  logic [AGE_W-1:0] age_q;

  // Counts every cycle the CPU is left waiting, including while another port is served.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      age_q <= '0;
    end else if (!cpu_req || (state_q == ST_IDLE && winner == P_CPU)) begin
      age_q <= '0;
    end else if (age_q != AGE_W'(AGE_LIMIT)) begin
      age_q <= age_q + 1'b1;
    end
  end

  assign cpu_aged = (age_q >= AGE_W'(AGE_LIMIT));
`else
  logic unused_age_limit;
  assign unused_age_limit = ^AGE_LIMIT;
  assign cpu_aged         = 1'b0;
`endif

  // Command of the current winner, latched on the IDLE -> ISSUE transition.
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    sel_be   = '0;
    case (winner)
      P_VID: begin
        sel_addr = vid_addr;
        sel_din  = vid_din;
        sel_be   = vid_be;
      end
      P_DL: begin
        sel_we   = dl_we;
        sel_addr = dl_addr;
        sel_din  = dl_din;
        sel_be   = dl_be;
      end
      P_CPU: begin
        sel_we   = cpu_we;
        sel_addr = cpu_addr;
        sel_din  = cpu_din;
        sel_be   = cpu_be;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= P_NONE;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_be   <= '0;
      rd_data  <= '0;
      vid_ack  <= 1'b0;
      dl_ack   <= 1'b0;
      cpu_ack  <= 1'b0;
    end else begin
      vid_ack <= 1'b0;
      dl_ack  <= 1'b0;
      cpu_ack <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (|req_vec) begin
            grant_q  <= winner;
            mem_req  <= 1'b1;
            mem_we   <= sel_we;
            mem_addr <= sel_addr;
            mem_din  <= sel_din;
            mem_be   <= sel_be;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            // Writes leave the last read value in place.
            if (!mem_we) begin
              rd_data <= mem_dout;
            end
            vid_ack <= (grant_q == P_VID);
            dl_ack  <= (grant_q == P_DL);
            cpu_ack <= (grant_q == P_CPU);
            state_q <= ST_ACK;
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: reset, directed corner sequences, a table of
// request patterns, and randomized request batches checked against a transaction-level model.
module tb_sdram_port_arbiter;
  import sdram_arb_pkg::*;

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = DW / 8;

`ifdef SDRAM_ARB_AGE_EN
  localparam bit AgeOn = 1'b1;
`else
  localparam bit AgeOn = 1'b0;
`endif

  logic          clk_sys = 1'b0;
  logic          rst_n   = 1'b0;
  logic          vid_req = 1'b0, dl_req = 1'b0, cpu_req = 1'b0;
  logic          vid_we = 1'b0, dl_we = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] vid_addr = '0, dl_addr = '0, cpu_addr = '0;
  logic [DW-1:0] vid_din = '0, dl_din = '0, cpu_din = '0;
  logic [BW-1:0] vid_be = '0, dl_be = '0, cpu_be = '0;
  logic          vid_ack, dl_ack, cpu_ack;
  logic [DW-1:0] rd_data;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [BW-1:0] mem_be;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_dout = '0;
  logic          busy;

  always #5 clk_sys = ~clk_sys;

  sdram_port_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .AGE_LIMIT (3)
  ) dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .vid_req  (vid_req),
    .vid_we   (vid_we),
    .vid_addr (vid_addr),
    .vid_din  (vid_din),
    .vid_be   (vid_be),
    .vid_ack  (vid_ack),
    .dl_req   (dl_req),
    .dl_we    (dl_we),
    .dl_addr  (dl_addr),
    .dl_din   (dl_din),
    .dl_be    (dl_be),
    .dl_ack   (dl_ack),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_be   (cpu_be),
    .cpu_ack  (cpu_ack),
    .rd_data  (rd_data),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_be   (mem_be),
    .mem_ack  (mem_ack),
    .mem_dout (mem_dout),
    .busy     (busy)
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] exp_rd  = '0;

  typedef struct packed {
    logic [2:0]  reqs;   // {vid, dl, cpu}
    logic [5:0]  order;  // expected grant order, first port in [5:4]
    logic [15:0] dout;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
  endtask

  function automatic logic [2:0] ack_of(input arb_port_t p);
    case (p)
      P_VID:   return 3'b100;
      P_DL:    return 3'b010;
      P_CPU:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] acks();
    return {vid_ack, dl_ack, cpu_ack};
  endfunction

  task automatic check_cmd(input arb_port_t p, input string tag);
    logic          ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [BW-1:0] eb;
    case (p)
      P_VID:   begin ew = 1'b0;   ea = vid_addr; ed = vid_din; eb = vid_be; end
      P_DL:    begin ew = dl_we;  ea = dl_addr;  ed = dl_din;  eb = dl_be;  end
      default: begin ew = cpu_we; ea = cpu_addr; ed = cpu_din; eb = cpu_be; end
    endcase
    check({tag, "_we"}, 32'(mem_we), 32'(ew));
    check({tag, "_addr"}, 32'(mem_addr), 32'(ea));
    check({tag, "_din"}, 32'(mem_din), 32'(ed));
    check({tag, "_be"}, 32'(mem_be), 32'(eb));
  endtask

  // Acts as the SDRAM controller for one transaction expected to belong to port p.
  task automatic serve(input arb_port_t p, input int delay, input logic [DW-1:0] dout,
                       input bit drop);
    int   w = 0;
    logic is_write;
    while (!mem_req && w < 12) begin
      tick();
      w++;
    end
    check("mem_req_seen", 32'(mem_req), 1);
    if (!mem_req) return;
    check_cmd(p, "cmd");
    check("busy_issue", 32'(busy), 1);
    for (int i = 0; i < delay; i++) begin
      tick();
      check("mem_req_hold", 32'(mem_req), 1);
      check("ack_early", 32'(acks()), 0);
      check_cmd(p, "cmd_stable");
    end
    case (p)
      P_DL:    is_write = dl_we;
      P_CPU:   is_write = cpu_we;
      default: is_write = 1'b0;
    endcase
    mem_ack  = 1'b1;
    mem_dout = dout;
    tick();
    mem_ack  = 1'b0;
    mem_dout = DW'($urandom);
    check("ack_port", 32'(acks()), 32'(ack_of(p)));
    check("mem_req_drop", 32'(mem_req), 0);
    if (!is_write) exp_rd = dout;
    check("rd_data", 32'(rd_data), 32'(exp_rd));
    if (drop) begin
      case (p)
        P_VID:   vid_req = 1'b0;
        P_DL:    dl_req  = 1'b0;
        default: cpu_req = 1'b0;
      endcase
    end
    tick();
    check("ack_one_cycle", 32'(acks()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) tick();
    check("reset_ctrl", 32'({vid_ack, dl_ack, cpu_ack, mem_req, mem_we, busy}), 0);
    check("reset_addr", 32'(mem_addr), 0);
    check("reset_din", 32'({mem_din, mem_be}), 0);
    check("reset_rd", 32'(rd_data), 0);
    rst_n = 1'b1;
    tick();

    // Stray mem_ack while idle is ignored
    mem_ack  = 1'b1;
    mem_dout = 16'h1234;
    tick();
    mem_ack = 1'b0;
    check("stray_ack", 32'(acks()), 0);
    check("stray_busy", 32'(busy), 0);
    check("stray_memreq", 32'(mem_req), 0);
    check("stray_rd", 32'(rd_data), 0);
    tick();
    check("stray_busy2", 32'(busy), 0);

    // Single CPU read, controller answers 4 cycles after mem_req
    cpu_we   = 1'b0;
    cpu_addr = 24'h000123;
    cpu_din  = 16'h0000;
    cpu_be   = 2'b11;
    cpu_req  = 1'b1;
    tick();
    check("first_latency", 32'(mem_req), 1);
    serve(P_CPU, 4, 16'hBEEF, 1'b1);

    // DL write: rd_data must keep the previous read value
    dl_we   = 1'b1;
    dl_addr = 24'h00ABCD;
    dl_din  = 16'h55AA;
    dl_be   = 2'b01;
    dl_req  = 1'b1;
    serve(P_DL, 3, 16'h1111, 1'b1);
    check("wr_rd_keep", 32'(rd_data), 32'h0000BEEF);

    // Request patterns raised in a single cycle
    tbl[0] = '{reqs: 3'b001, order: {P_CPU, P_NONE, P_NONE}, dout: 16'h0A01};
    tbl[1] = '{reqs: 3'b010, order: {P_DL,  P_NONE, P_NONE}, dout: 16'h0B02};
    tbl[2] = '{reqs: 3'b100, order: {P_VID, P_NONE, P_NONE}, dout: 16'h0C03};
    if (AgeOn) tbl[3] = '{reqs: 3'b111, order: {P_VID, P_CPU, P_DL}, dout: 16'h0D04};
    else       tbl[3] = '{reqs: 3'b111, order: {P_VID, P_DL, P_CPU}, dout: 16'h0D04};
    tbl[4] = '{reqs: 3'b011, order: {P_DL,  P_CPU, P_NONE}, dout: 16'h0E05};
    tbl[5] = '{reqs: 3'b101, order: {P_VID, P_CPU, P_NONE}, dout: 16'h0F06};
    tbl[6] = '{reqs: 3'b110, order: {P_VID, P_DL,  P_NONE}, dout: 16'h1007};
    for (int i = 0; i < 7; i++) begin
      vid_we = 1'b1; vid_addr = AW'(24'h010000 + i); vid_din = 16'hAAAA; vid_be = 2'b10;
      dl_we  = 1'b0; dl_addr  = AW'(24'h020000 + i); dl_din  = 16'hBBBB; dl_be  = 2'b01;
      cpu_we = 1'b0; cpu_addr = AW'(24'h030000 + i); cpu_din = 16'hCCCC; cpu_be = 2'b11;
      {vid_req, dl_req, cpu_req} = tbl[i].reqs;
      for (int k = 0; k < 3; k++) begin
        logic [5:0] ord;
        arb_port_t  p;
        ord = tbl[i].order;
        p   = arb_port_t'(ord[5-2*k -: 2]);
        if (p != P_NONE) serve(p, k, tbl[i].dout ^ DW'(k), 1'b1);
      end
      tick();
      check("tbl_no_extra_req", 32'(mem_req), 0);
      check("tbl_idle", 32'(busy), 0);
    end

    // DL back-to-back with CPU held
    dl_we = 1'b0; dl_addr = 24'h000222;
    cpu_we = 1'b0; cpu_addr = 24'h000333;
    dl_req = 1'b1; cpu_req = 1'b1;
`ifdef SDRAM_ARB_AGE_EN
    serve(P_DL, 1, 16'hD001, 1'b0);
    serve(P_CPU, 1, 16'hC001, 1'b1);
    serve(P_DL, 1, 16'hD002, 1'b1);
`else
    serve(P_DL, 1, 16'hD001, 1'b0);
    serve(P_DL, 1, 16'hD002, 1'b0);
    serve(P_DL, 1, 16'hD003, 1'b1);
    serve(P_CPU, 1, 16'hC001, 1'b1);
`endif

    // Reset while ISSUE is waiting for the controller
    cpu_we = 1'b0; cpu_addr = 24'h000777;
    cpu_req = 1'b1;
    tick();
    check("pre_rst_memreq", 32'(mem_req), 1);
    rst_n = 1'b0;
    #1;
    check("rst_memreq", 32'(mem_req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_addr", 32'(mem_addr), 0);
    exp_rd = '0;
    tick();
    check("rst_no_ack", 32'(acks()), 0);
    rst_n = 1'b1;
    tick();
    check("rst_reserve", 32'(mem_req), 1);
    serve(P_CPU, 1, 16'hC0DE, 1'b1);

    // Randomized batches. Every transaction lasts at least three cycles, so with AGE_LIMIT=3
    // a CPU that has lost one grant is already aged at the next arbitration.
    for (int r = 0; r < 40; r++) begin
      logic [2:0] m;
      bit         pv, pd, pc, cpu_lost;
      arb_port_t  w;
      m = 3'($urandom_range(1, 7));
      vid_we = 1'($urandom); vid_addr = AW'($urandom); vid_din = DW'($urandom);
      vid_be = BW'($urandom);
      dl_we  = 1'($urandom); dl_addr  = AW'($urandom); dl_din  = DW'($urandom);
      dl_be  = BW'($urandom);
      cpu_we = 1'($urandom); cpu_addr = AW'($urandom); cpu_din = DW'($urandom);
      cpu_be = BW'($urandom);
      {vid_req, dl_req, cpu_req} = m;
      {pv, pd, pc} = m;
      cpu_lost = 1'b0;
      while (pv || pd || pc) begin
        if (pv)                           w = P_VID;
        else if (AgeOn && pc && cpu_lost) w = P_CPU;
        else if (pd)                      w = P_DL;
        else                              w = P_CPU;
        serve(w, $urandom_range(0, 3), DW'($urandom), 1'b1);
        case (w)
          P_VID:   pv = 1'b0;
          P_DL:    pd = 1'b0;
          default: pc = 1'b0;
        endcase
        if (w != P_CPU && pc) cpu_lost = 1'b1;
      end
      tick();
      check("rand_idle", 32'(busy), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
